acc_requant_stage: RTL and testbench
====================================

Name: acc_requant_stage

Overview:
- Downstream consumer of the mac_unit chain (N=16, SUM_WIDTH=36).
- Accumulates cfg_num_ch partial sums per output pixel, then adds bias, applies rounded arithmetic right shift, optional ReLU and saturation to int16.
- Emits one int16 activation per group over a valid/ready handshake to the next layer's input buffer.

Parameters:
- N, 16, output/activation width (bits).
- SUM_WIDTH, 2*N+4, width of incoming psum and of bias.
- CH_MAX, 64, maximum channels per group; ACC_W = SUM_WIDTH + clog2(CH_MAX).
- SHIFT_W, 6, width of cfg_shift.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  psum beat valid.
- in_ready  out  1  stage can accept a psum beat.
- in_psum  in  SUM_WIDTH  signed partial sum (mac_out).
- cfg_num_ch  in  clog2(CH_MAX)+1  beats per group; 0 treated as 1.
- cfg_bias  in  SUM_WIDTH  signed bias, same scale as psum.
- cfg_shift  in  SHIFT_W  right-shift amount, 0..ACC_W-1.
- cfg_relu  in  1  1 = clamp negatives to 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  N  signed requantised activation.
- out_sat  out  1  out_data was clipped by saturation.

Behaviour:
- Reset (async): state=IDLE, acc=0, beat count=0, out_valid=0, out_data=0, out_sat=0, in_ready=0 while rst high, 1 the cycle after release.
- Beat accepted when in_valid && in_ready.
- FSM IDLE -> ACCUM -> REQUANT -> IDLE.
  - IDLE: first accepted beat latches cfg_num_ch/bias/shift/relu into shadow regs. acc <= sign-extended psum, cnt <= 1. Go to REQUANT if num_ch<=1, else ACCUM.
  - ACCUM: each accepted beat: acc += psum, cnt++. On beat where cnt+1 == num_ch, go to REQUANT. cfg_* changes mid-group are ignored.
  - REQUANT: in_ready=0. Compute t = acc + bias (ACC_W+1 bits, no overflow). If shift>0, r = (t + 2^(shift-1)) >>> shift (round half up), else r = t. If relu and r<0, r=0. Clip r to [-2^(N-1), 2^(N-1)-1]; out_sat=1 iff clipped.
    - Result loads into the output register only when out_valid==0 || out_ready; otherwise stay in REQUANT (stall).
    - On load go to IDLE with acc cleared.
- in_ready = (state==IDLE || state==ACCUM) && !rst.
  - Accumulation of the next group continues while a result is pending; stall occurs only at REQUANT.
- Latency: last beat accepted at cycle t -> out_valid high at t+2 when the output is free.
- Output hold: out_data/out_sat stable while out_valid && !out_ready. out_valid drops the cycle after acceptance unless a new result loads in the same cycle (back-to-back allowed).
- in_valid low mid-group: state and count hold indefinitely.
- Reset mid-group or mid-stall: partial group discarded, pending output dropped.

Optional Feature:
- Macro ACC_REQUANT_SAT_CNT_EN.
- Defined: extra output port sat_count (16 bits). Increments on each accepted output with out_sat=1, saturates at 0xFFFF, async reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: N, SUM_WIDTH default, ACC_W function (clog2), FSM state encoding constants, INT16_MAX/INT16_MIN.
- One sub-module: requant_sat (combinational bias-add, round-shift, ReLU, clip). Reusable by other layer outputs.

Test Plan:
- num_ch=4, psums 100,200,-50,30, bias=20, shift=2, relu=0 -> acc=280, t=300, out_data=75, out_sat=0, out_valid at last-beat+2.
- num_ch=1, psum=-1000, bias=0, shift=0, relu=1 -> out_data=0, out_sat=0. Same with relu=0 -> out_data=-1000.
- num_ch=2, psums 40000,40000, shift=0 -> out_data=32767, out_sat=1. Psums -40000,-40000 -> -32768, out_sat=1.
- Rounding: acc=5 and acc=-5, shift=1 -> 3 and -2.
- out_ready held low: two groups sent back-to-back. First result holds stable; second group accumulates, then FSM stalls in REQUANT with in_ready=0. Raise out_ready -> second result appears next cycle, nothing lost.
- Assert rst mid-ACCUM after 2 of 4 beats -> outputs zero immediately. New 4-beat group yields the correct result, no residue.

Source files
------------

// File: rtl/acc_requant_pkg.sv
// acc_requant_pkg
// Shared constants and types for the accumulate/requantise output stage.
// Holds the default datapath widths, the accumulator width helper, the FSM
// state encoding and the int16 clip limits. Imported by acc_requant_stage
// and requant_sat.
package acc_requant_pkg;

  localparam int DEFAULT_N         = 16;
  localparam int DEFAULT_SUM_WIDTH = 2 * DEFAULT_N + 4;
  localparam int DEFAULT_CH_MAX    = 64;
  localparam int DEFAULT_SHIFT_W   = 6;

  // Accumulator width: enough headroom to sum ch_max full-scale psums.
  function automatic int acc_width(input int sum_w, input int ch_max);
    return sum_w + $clog2(ch_max);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_REQUANT = 2'd2
  } state_t;

  localparam logic signed [15:0] INT16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] INT16_MIN = 16'sh8000;

endpackage

// File: rtl/acc_requant_sat.sv
// requant_sat
// Combinational requantiser: adds bias to an accumulator, applies a rounded
// (round-half-up) arithmetic right shift, optional ReLU, then clips the
// result to a signed N-bit range.
// Ports:
//   acc   in  ACC_W      signed accumulator
//   bias  in  SUM_WIDTH  signed bias, same scale as acc
//   shift in  SHIFT_W    right-shift amount
//   relu  in  1          clamp negative results to zero
//   data  out N          signed clipped result
//   sat   out 1          result was clipped
module requant_sat
  import acc_requant_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int ACC_W     = 42,
  parameter int SUM_WIDTH = DEFAULT_SUM_WIDTH,
  parameter int SHIFT_W   = DEFAULT_SHIFT_W
) (
  input  logic signed [ACC_W-1:0]     acc,
  input  logic signed [SUM_WIDTH-1:0] bias,
  input  logic [SHIFT_W-1:0]          shift,
  input  logic                        relu,
  output logic signed [N-1:0]         data,
  output logic                        sat
);

  // Two guard bits: one for the bias add, one for the rounding increment.
  localparam int W = ACC_W + 2;
  localparam logic signed [W-1:0] MAX_V = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [W-1:0] t;
  logic signed [W-1:0] half;
  logic signed [W-1:0] r;

  always_comb begin
    t    = W'(acc) + W'(bias);
    half = '0;
    if (shift != '0) begin
      half = W'(1) << (shift - SHIFT_W'(1));
    end
    r = (t + half) >>> shift;
    if (relu && r[W-1]) begin
      r = '0;
    end
    data = r[N-1:0];
    sat  = 1'b0;
    if (r > MAX_V) begin
      data = MAX_V[N-1:0];
      sat  = 1'b1;
    end else if (r < MIN_V) begin
      data = MIN_V[N-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/acc_requant_stage.sv
// acc_requant_stage
// Accumulates cfg_num_ch partial sums per output pixel, then requantises the
// total (bias add, rounded shift, optional ReLU, int16 clip) and hands one
// activation per group downstream over valid/ready.
// Optional build macro ACC_REQUANT_SAT_CNT_EN adds a saturating 16-bit count
// of accepted outputs that were clipped (port sat_count).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   psum beat handshake, in_psum signed partial sum
//   cfg_num_ch          beats per group (0 behaves as 1)
//   cfg_bias/shift/relu requantisation config, sampled on a group's first beat
//   out_valid/out_ready result handshake, out_data activation, out_sat clipped
//   sat_count           (macro only) clipped-output counter
module acc_requant_stage
  import acc_requant_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int SUM_WIDTH = DEFAULT_SUM_WIDTH,
  parameter int CH_MAX    = DEFAULT_CH_MAX,
  parameter int SHIFT_W   = DEFAULT_SHIFT_W,
  localparam int ACC_W    = acc_width(SUM_WIDTH, CH_MAX),
  localparam int CNT_W    = $clog2(CH_MAX) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SUM_WIDTH-1:0] in_psum,
  input  logic [CNT_W-1:0]            cfg_num_ch,
  input  logic signed [SUM_WIDTH-1:0] cfg_bias,
  input  logic [SHIFT_W-1:0]          cfg_shift,
  input  logic                        cfg_relu,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [N-1:0]         out_data,
`ifdef ACC_REQUANT_SAT_CNT_EN
  output logic [15:0]                 sat_count,
`endif
  output logic                        out_sat
);

  state_t                      state;
  logic signed [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            num_ch_q;
  logic signed [SUM_WIDTH-1:0] bias_q;
  logic [SHIFT_W-1:0]          shift_q;
  logic                        relu_q;

  logic                        beat;
  logic [CNT_W-1:0]            num_ch_eff;
  logic signed [ACC_W-1:0]     psum_ext;
  logic signed [N-1:0]         rq_data;
  logic                        rq_sat;

  // Gated by rst so the stage never advertises readiness while held in reset.
  assign in_ready   = ((state == ST_IDLE) || (state == ST_ACCUM)) && !rst;
  assign beat       = in_valid && in_ready;
  assign num_ch_eff = (cfg_num_ch == '0) ? CNT_W'(1) : cfg_num_ch;
  assign psum_ext   = ACC_W'(in_psum);

  requant_sat #(
    .N         (N),
    .ACC_W     (ACC_W),
    .SUM_WIDTH (SUM_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_requant (
    .acc   (acc),
    .bias  (bias_q),
    .shift (shift_q),
    .relu  (relu_q),
    .data  (rq_data),
    .sat   (rq_sat)
  );

  // Group FSM plus output register. The output register is freed by a
  // downstream accept; a REQUANT load in the same cycle overrides that so
  // results can go out back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      num_ch_q  <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (beat) begin
            num_ch_q <= num_ch_eff;
            bias_q   <= cfg_bias;
            shift_q  <= cfg_shift;
            relu_q   <= cfg_relu;
            acc      <= psum_ext;
            cnt      <= CNT_W'(1);
            state    <= (num_ch_eff <= CNT_W'(1)) ? ST_REQUANT : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc <= acc + psum_ext;
            cnt <= cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == num_ch_q) begin
              state <= ST_REQUANT;
            end
          end
        end
        ST_REQUANT: begin
          if (!out_valid || out_ready) begin
            out_data  <= rq_data;
            out_sat   <= rq_sat;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACC_REQUANT_SAT_CNT_EN
  // Counts clipped results as they are accepted downstream; sticks at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_requant_stage.sv
// tb_acc_requant_stage
// Directed, table-driven bench for acc_requant_stage: a table of groups with
// hand-computed results, followed by back-pressure and mid-group reset
// sequences.
module tb_acc_requant_stage;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [35:0] in_psum;
  logic [6:0]         cfg_num_ch;
  logic signed [35:0] cfg_bias;
  logic [5:0]         cfg_shift;
  logic               cfg_relu;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
`ifdef ACC_REQUANT_SAT_CNT_EN
  logic [15:0]        sat_count;
`endif

  int tests  = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]        num_ch;
    logic [3:0][35:0]  psum;
    logic [35:0]       bias;
    logic [5:0]        shift;
    logic              relu;
    logic [15:0]       exp_data;
    logic              exp_sat;
  } vec_t;

  vec_t vecs [11];

  acc_requant_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_psum    (in_psum),
    .cfg_num_ch (cfg_num_ch),
    .cfg_bias   (cfg_bias),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef ACC_REQUANT_SAT_CNT_EN
    .sat_count  (sat_count),
`endif
    .out_sat    (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input int nch, input int p0, input int p1,
                              input int p2, input int p3, input int bias,
                              input int sh, input bit relu, input int exp_d,
                              input bit exp_s);
    vec_t v;
    v.num_ch   = 7'(nch);
    v.psum[0]  = 36'(p0);
    v.psum[1]  = 36'(p1);
    v.psum[2]  = 36'(p2);
    v.psum[3]  = 36'(p3);
    v.bias     = 36'(bias);
    v.shift    = 6'(sh);
    v.relu     = relu;
    v.exp_data = 16'(exp_d);
    v.exp_sat  = exp_s;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives nbeats psums of a group. cfg_* is presented with the first beat and
  // scrambled afterwards, so a correct stage must use its latched copy.
  // Returns at the negedge just after the last beat was accepted.
  task automatic applyStimulus(input vec_t v, input int nbeats, input bit gap);
    int w;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (b == 0) begin
        cfg_num_ch = v.num_ch;
        cfg_bias   = v.bias;
        cfg_shift  = v.shift;
        cfg_relu   = v.relu;
      end else begin
        cfg_num_ch = 7'd1;
        cfg_bias   = ~v.bias;
        cfg_shift  = v.shift ^ 6'd1;
        cfg_relu   = ~v.relu;
      end
      in_valid = 1'b1;
      in_psum  = v.psum[b];
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        checkOutput("in_ready_timeout", 0, 1);
      end
      if (gap && b < nbeats - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid   = 1'b0;
    cfg_num_ch = 7'd1;
    cfg_bias   = ~v.bias;
    cfg_shift  = v.shift ^ 6'd1;
    cfg_relu   = ~v.relu;
  endtask

  initial begin
    int nb;
    vec_t vx;
    vec_t vy;
    vec_t vp;

    vecs[0]  = mk(4, 100, 200, -50, 30, 20, 2, 1'b0, 75, 1'b0);
    vecs[1]  = mk(1, -1000, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0);
    vecs[2]  = mk(1, -1000, 0, 0, 0, 0, 0, 1'b0, -1000, 1'b0);
    vecs[3]  = mk(2, 40000, 40000, 0, 0, 0, 0, 1'b0, 32767, 1'b1);
    vecs[4]  = mk(2, -40000, -40000, 0, 0, 0, 0, 1'b0, -32768, 1'b1);
    vecs[5]  = mk(1, 5, 0, 0, 0, 0, 1, 1'b0, 3, 1'b0);
    vecs[6]  = mk(1, -5, 0, 0, 0, 0, 1, 1'b0, -2, 1'b0);
    vecs[7]  = mk(0, 7, 0, 0, 0, 3, 0, 1'b0, 10, 1'b0);
    vecs[8]  = mk(1, 100000, 0, 0, 0, 0, 0, 1'b1, 32767, 1'b1);
    vecs[9]  = mk(1, 1048576, 0, 0, 0, 0, 10, 1'b0, 1024, 1'b0);
    vecs[10] = mk(3, 10, 20, 30, 0, -100, 0, 1'b1, 0, 1'b0);

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_psum    = '0;
    cfg_num_ch = '0;
    cfg_bias   = '0;
    cfg_shift  = '0;
    cfg_relu   = 1'b0;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      nb = (vecs[i].num_ch == 7'd0) ? 1 : int'(vecs[i].num_ch);
      applyStimulus(vecs[i], nb, i[0]);
      checkOutput($sformatf("v%0d_valid_t+1", i), out_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid_t+2", i), out_valid, 1);
      checkOutput($sformatf("v%0d_data", i), out_data, $signed(vecs[i].exp_data));
      checkOutput($sformatf("v%0d_sat", i), out_sat, vecs[i].exp_sat);
    end

`ifdef ACC_REQUANT_SAT_CNT_EN
    @(negedge clk);
    checkOutput("sat_count", sat_count, 3);
`endif

    // Back-pressure: first result must hold while the second group stalls.
    vx = mk(2, 1000, 2000, 0, 0, 0, 0, 1'b0, 3000, 1'b0);
    vy = mk(2, -300, -400, 0, 0, 0, 0, 1'b0, -700, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(vx, 2, 1'b0);
    @(negedge clk);
    checkOutput("bp_first_valid", out_valid, 1);
    checkOutput("bp_first_data", out_data, 3000);
    applyStimulus(vy, 2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_stall%0d_in_ready", k), in_ready, 0);
      checkOutput($sformatf("bp_stall%0d_valid", k), out_valid, 1);
      checkOutput($sformatf("bp_stall%0d_data", k), out_data, 3000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_valid", out_valid, 1);
    checkOutput("bp_second_data", out_data, -700);
    checkOutput("bp_second_in_ready", in_ready, 1);
    @(negedge clk);
    checkOutput("bp_drained_valid", out_valid, 0);

    // Reset mid-group with a result pending downstream.
    vp = mk(1, 500, 0, 0, 0, 0, 0, 1'b0, 500, 1'b0);
    out_ready = 1'b0;
    applyStimulus(vp, 1, 1'b0);
    @(negedge clk);
    checkOutput("rst_pending_data", out_data, 500);
    applyStimulus(vecs[0], 2, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_data", out_data, 0);
    checkOutput("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", in_ready, 1);
    applyStimulus(vecs[0], 4, 1'b0);
    checkOutput("rst_regroup_valid_t+1", out_valid, 0);
    @(negedge clk);
    checkOutput("rst_regroup_valid_t+2", out_valid, 1);
    checkOutput("rst_regroup_data", out_data, 75);
    checkOutput("rst_regroup_sat", out_sat, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
